audio_packet_scheduler: RTL and testbench

Sequences the HDMI audio sample packet datapath. It buffers incoming stereo sample pairs in a small FIFO and groups up to four pairs per packet. It then presents the packet fields (frame counter, sample words, present mask) to the audio sample packet encoder through a valid/ready handshake with the data-island packet picker. It also owns the 192-frame IEC 60958 channel-status frame counter, advancing it only when a packet is accepted.

---
 rtl/audio_packet_scheduler_if.sv | 53 +++++
 rtl/audio_packet_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_audio_packet_scheduler.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_packet_scheduler_if.sv
// Stream interfaces around the audio packet scheduler.
// sample_stream_if carries stereo pairs into the scheduler; packet_stream_if
// carries assembled audio sample packet fields out to the data-island picker.

interface sample_stream_if;
    logic        sample_valid;
    logic        sample_ready;
    logic [23:0] sample_left;
    logic [23:0] sample_right;

    // Source of stereo pairs (e.g. the audio capture front end).
    modport master (
        output sample_valid,
        output sample_left,
        output sample_right,
        input  sample_ready
    );

    // Consumer of stereo pairs (the scheduler).
    modport slave (
        input  sample_valid,
        input  sample_left,
        input  sample_right,
        output sample_ready
    );
endinterface

interface packet_stream_if;
    logic                   pkt_valid;
    logic                   pkt_ready;
    logic [7:0]             frame_counter;
    // Per slot: index 0 is the left word, index 1 is the right word.
    logic [3:0][1:0][23:0]  audio_sample_word;
    logic [3:0]             audio_sample_word_present;

    // Packet producer (the scheduler).
    modport master (
        output pkt_valid,
        output frame_counter,
        output audio_sample_word,
        output audio_sample_word_present,
        input  pkt_ready
    );

    // Packet consumer (the data-island packet picker).
    modport slave (
        input  pkt_valid,
        input  frame_counter,
        input  audio_sample_word,
        input  audio_sample_word_present,
        output pkt_ready
    );
endinterface

// File: rtl/audio_packet_scheduler.sv
// HDMI audio sample packet scheduler.
// Buffers stereo pairs in a small FIFO, groups up to four pairs per packet,
// offers the packet to the picker with valid/ready and owns the 192-frame
// IEC 60958 channel-status frame counter, which advances only on acceptance.

module audio_packet_scheduler #(
    parameter int FIFO_DEPTH = 8,     // power of two, >= 4
    parameter int MAX_WAIT   = 1024   // idle cycles before a partial flush, >= 1
) (
    input  logic                          clk_pixel,
    input  logic                          reset,
    sample_stream_if.slave                samples,
    packet_stream_if.master               packets,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [LVL_W-1:0]  LVL_FULL   = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  LVL_PKT    = LVL_W'(4);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [8:0]        FRAMES     = 9'd192;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        OFFER
    } state_t;

    // One stereo pair: [0] is left, [1] is right (same layout as a packet slot).
    typedef logic [1:0][23:0] pair_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t                 state;
    state_t                 state_next;

    pair_t                  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level;
    logic [LVL_W-1:0]       level_next;
    logic                   ready_q;
    logic                   overflow_q;
    logic                   push;
    logic                   pop;

    logic [WAIT_W-1:0]      wait_cnt;
    logic                   start_load;
    logic                   load_done;
    logic                   accept;

    logic [2:0]             pkt_count;   // pairs in the current packet, 1..4
    logic [1:0]             load_idx;    // next slot to fill during LOAD
    logic [3:0][1:0][23:0]  slot;
    logic [7:0]             frame_cnt;
    logic [8:0]             frame_sum;
    logic [8:0]             frame_wrapped;

    logic                   pkt_valid_c;
    logic [3:0]             present_c;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign push = samples.sample_valid && ready_q;

    // Occupancy after this cycle's push/pop; push+pop together is a no-op.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        level_next = level;
        unique case ({push, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    // Pair storage: written on push, read at rd_ptr during LOAD.
    always_ff @(posedge clk_pixel) begin
        // NOTE: the storage array has no reset; pointers and level alone define
        // which entries are valid, so stale contents are never observed.
        if (push) begin
            mem[wr_ptr] <= {samples.sample_right, samples.sample_left};
        end
    end

    // Pointers, level, registered ready and sticky overflow.
    always_ff @(posedge clk_pixel) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level      <= level_next;
            ready_q    <= (level_next != LVL_FULL);
            overflow_q <= overflow_q | (samples.sample_valid && !ready_q);
        end
    end

    // ------------------------------------------------------------------
    // Partial-packet wait counter
    // ------------------------------------------------------------------
    // Counts idle cycles with 1..3 buffered pairs, saturating at MAX_WAIT.
    always_ff @(posedge clk_pixel) begin
        if (reset || state != IDLE || level == '0) begin
            wait_cnt <= '0;
        end else if (level < LVL_PKT && wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign start_load = (level >= LVL_PKT) ||
                        (level != '0 && wait_cnt == WAIT_LIMIT);

    assign load_done  = ({1'b0, load_idx} == (pkt_count - 3'd1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_load)        state_next = LOAD;
            LOAD:    if (load_done)         state_next = OFFER;
            OFFER:   if (packets.pkt_ready) state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // State-decoded outputs: pop during LOAD, offer and mask during OFFER.
    always_comb begin
        pop         = 1'b0;
        accept      = 1'b0;
        pkt_valid_c = 1'b0;
        present_c   = 4'b0000;
        unique case (state)
            LOAD: begin
                pop = 1'b1;
            end
            OFFER: begin
                pkt_valid_c = 1'b1;
                accept      = packets.pkt_ready;
                unique case (pkt_count)
                    3'd1:    present_c = 4'b0001;
                    3'd2:    present_c = 4'b0011;
                    3'd3:    present_c = 4'b0111;
                    default: present_c = 4'b1111;
                endcase
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Packet datapath
    // ------------------------------------------------------------------
    // Frame counter advance, kept 9 bits wide so the 192 wrap is exact.
    assign frame_sum     = {1'b0, frame_cnt} + {6'd0, pkt_count};
    assign frame_wrapped = (frame_sum >= FRAMES) ? (frame_sum - FRAMES) : frame_sum;

    // Packet size latch, slot fill during LOAD, frame advance and clear on accept.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            pkt_count <= 3'd0;
            load_idx  <= 2'd0;
            slot      <= '0;
            frame_cnt <= 8'd0;
        end else begin
            if (state == IDLE && start_load) begin
                pkt_count <= (level >= LVL_PKT) ? 3'd4 : level[2:0];
                load_idx  <= 2'd0;
                slot      <= '0;
            end
            if (pop) begin
                slot[load_idx] <= mem[rd_ptr];
                load_idx       <= load_idx + 1'b1;
            end
            if (accept) begin
                frame_cnt <= frame_wrapped[7:0];
                slot      <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign samples.sample_ready               = ready_q;
    assign packets.pkt_valid                  = pkt_valid_c;
    assign packets.frame_counter              = frame_cnt;
    assign packets.audio_sample_word          = slot;
    assign packets.audio_sample_word_present  = present_c;
    assign fifo_level                         = level;
    assign overflow                           = overflow_q;

endmodule

// File: tb/tb_audio_packet_scheduler.sv
// Directed self-checking bench for audio_packet_scheduler
// (FIFO_DEPTH = 8, MAX_WAIT = 16).

module tb_audio_packet_scheduler;

    localparam int DEPTH = 8;
    localparam int WAIT  = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] fifo_level;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    sample_stream_if s_if ();
    packet_stream_if p_if ();

    audio_packet_scheduler #(
        .FIFO_DEPTH (DEPTH),
        .MAX_WAIT   (WAIT)
    ) dut (
        .clk_pixel  (clk),
        .reset      (reset),
        .samples    (s_if),
        .packets    (p_if),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one pair for one cycle.
    task automatic push(input logic [23:0] l, input logic [23:0] r);
        s_if.sample_valid = 1'b1;
        s_if.sample_left  = l;
        s_if.sample_right = r;
        step();
        s_if.sample_valid = 1'b0;
    endtask

    function automatic logic [191:0] words_of(input int n, input logic [23:0] lb, input logic [23:0] rb);
        logic [3:0][1:0][23:0] w;
        w = '0;
        for (int k = 0; k < n; k++) begin
            w[k][0] = lb + 24'(k);
            w[k][1] = rb + 24'(k);
        end
        return w;
    endfunction

    function automatic logic [3:0] mask_of(input int n);
        logic [4:0] m;
        m = (5'd1 << n) - 5'd1;
        return m[3:0];
    endfunction

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        while (p_if.pkt_valid !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        check("pkt_valid_within_budget", p_if.pkt_valid, 1'b1);
    endtask

    // Wait for a packet, check it against the expected contents, accept it.
    task automatic expect_packet(input int n, input logic [23:0] lb, input logic [23:0] rb,
                                 input logic [7:0] exp_fc, input string tag);
        p_if.pkt_ready = 1'b1;
        wait_valid(64);
        check({tag, "_fc"},    p_if.frame_counter, exp_fc);
        check({tag, "_mask"},  p_if.audio_sample_word_present, mask_of(n));
        check({tag, "_words"}, p_if.audio_sample_word, words_of(n, lb, rb));
        step();
        check({tag, "_valid_drop"}, p_if.pkt_valid, 1'b0);
    endtask

    task automatic run_packet(input int n, input logic [23:0] lb, input logic [23:0] rb,
                              input logic [7:0] exp_fc, input string tag);
        for (int i = 0; i < n; i++) begin
            push(lb + 24'(i), rb + 24'(i));
        end
        expect_packet(n, lb, rb, exp_fc, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        s_if.sample_valid = 1'b0;
        s_if.sample_left  = '0;
        s_if.sample_right = '0;
        p_if.pkt_ready    = 1'b0;
        step();
        step();

        // Reset values
        check("rst_sample_ready", s_if.sample_ready, 1'b1);
        check("rst_pkt_valid",    p_if.pkt_valid, 1'b0);
        check("rst_frame",        p_if.frame_counter, 8'd0);
        check("rst_words",        p_if.audio_sample_word, 192'd0);
        check("rst_mask",         p_if.audio_sample_word_present, 4'd0);
        check("rst_level",        fifo_level, 4'd0);
        check("rst_overflow",     overflow, 1'b0);

        // Full packet latency: 4th push in cycle 0 -> pkt_valid in cycle 6
        reset          = 1'b0;
        p_if.pkt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(24'h000001 + 24'(i), 24'h100001 + 24'(i));
        end
        for (int c = 1; c < 6; c++) begin
            check("t1_valid_low", p_if.pkt_valid, 1'b0);
            step();
        end
        check("t1_valid",  p_if.pkt_valid, 1'b1);
        check("t1_mask",   p_if.audio_sample_word_present, 4'b1111);
        check("t1_frame",  p_if.frame_counter, 8'd0);
        check("t1_words",  p_if.audio_sample_word, words_of(4, 24'h000001, 24'h100001));
        check("t1_level",  fifo_level, 4'd0);
        step();
        check("t1_valid_drop", p_if.pkt_valid, 1'b0);
        check("t1_frame_adv",  p_if.frame_counter, 8'd4);
        check("t1_mask_idle",  p_if.audio_sample_word_present, 4'd0);
        check("t1_words_clr",  p_if.audio_sample_word, 192'd0);

        // Single-pair flush after MAX_WAIT idle cycles
        push(24'h0000A1, 24'h0000B1);
        for (int c = 1; c <= WAIT + 2; c++) begin
            check("t2_valid_low", p_if.pkt_valid, 1'b0);
            step();
        end
        check("t2_valid", p_if.pkt_valid, 1'b1);
        check("t2_mask",  p_if.audio_sample_word_present, 4'b0001);
        check("t2_words", p_if.audio_sample_word, words_of(1, 24'h0000A1, 24'h0000B1));
        check("t2_frame", p_if.frame_counter, 8'd4);
        step();
        check("t2_frame_adv", p_if.frame_counter, 8'd5);

        // Frame counter wrap at 192
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t3_frame_start", p_if.frame_counter, 8'd0);
        for (int p = 0; p < 47; p++) begin
            run_packet(4, 24'h000001, 24'h100001, 8'(4 * p), "t3_n4");
        end
        check("t3_frame_188", p_if.frame_counter, 8'd188);
        run_packet(3, 24'h000001, 24'h100001, 8'd188, "t3_n3");
        check("t3_frame_191", p_if.frame_counter, 8'd191);
        run_packet(4, 24'h000001, 24'h100001, 8'd191, "t3_last");
        check("t3_frame_wrap", p_if.frame_counter, 8'd3);

        // Backpressure: outputs held for 20 cycles while 3 more pairs arrive
        p_if.pkt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(24'h000011 + 24'(i), 24'h000021 + 24'(i));
        end
        wait_valid(16);
        for (int i = 0; i < 20; i++) begin
            check("t4_hold_valid", p_if.pkt_valid, 1'b1);
            check("t4_hold_frame", p_if.frame_counter, 8'd3);
            check("t4_hold_mask",  p_if.audio_sample_word_present, 4'b1111);
            check("t4_hold_words", p_if.audio_sample_word, words_of(4, 24'h000011, 24'h000021));
            if (i < 3) push(24'h000031 + 24'(i), 24'h000041 + 24'(i));
            else step();
        end
        check("t4_level", fifo_level, 4'd3);
        expect_packet(4, 24'h000011, 24'h000021, 8'd3, "t4_release");
        check("t4_frame_adv", p_if.frame_counter, 8'd7);
        expect_packet(3, 24'h000031, 24'h000041, 8'd7, "t4_partial");
        check("t4_frame_end", p_if.frame_counter, 8'd10);

        // Overflow: 13 back-to-back offers with the picker stalled
        reset = 1'b1;
        step();
        reset          = 1'b0;
        p_if.pkt_ready = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            if (i == 13) begin
                check("t5_ready_low",   s_if.sample_ready, 1'b0);
                check("t5_level_full",  fifo_level, 4'd8);
                check("t5_no_ovf_yet",  overflow, 1'b0);
            end
            push(24'h000100 + 24'(i), 24'h200100 + 24'(i));
        end
        check("t5_overflow",  overflow, 1'b1);
        check("t5_level",     fifo_level, 4'd8);
        check("t5_valid",     p_if.pkt_valid, 1'b1);
        expect_packet(4, 24'h000101, 24'h200101, 8'd0, "t5_pkt1");
        expect_packet(4, 24'h000105, 24'h200105, 8'd4, "t5_pkt2");
        check("t5_ready_back", s_if.sample_ready, 1'b1);
        expect_packet(4, 24'h000109, 24'h200109, 8'd8, "t5_pkt3");
        check("t5_frame",      p_if.frame_counter, 8'd12);
        check("t5_ovf_sticky", overflow, 1'b1);
        check("t5_level_end",  fifo_level, 4'd0);

        // Reset in the third LOAD cycle discards everything
        p_if.pkt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(24'h000051 + 24'(i), 24'h000061 + 24'(i));
        end
        step();
        step();
        step();
        check("t6_level_mid", fifo_level, 4'd2);
        reset = 1'b1;
        step();
        check("t6_valid",    p_if.pkt_valid, 1'b0);
        check("t6_level",    fifo_level, 4'd0);
        check("t6_frame",    p_if.frame_counter, 8'd0);
        check("t6_mask",     p_if.audio_sample_word_present, 4'd0);
        check("t6_words",    p_if.audio_sample_word, 192'd0);
        check("t6_overflow", overflow, 1'b0);
        check("t6_ready",    s_if.sample_ready, 1'b1);
        reset = 1'b0;
        run_packet(4, 24'h000071, 24'h000081, 8'd0, "t6_clean");
        check("t6_frame_adv", p_if.frame_counter, 8'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
